// File: rtl/fpmul_io_sequencer_pkg.sv
// fpmul_pkg: shared types and constants for the FP multiplier I/O sequencer.
//   state_t        - sequencer FSM states
//   FP_QNAN        - quiet NaN returned on multiplier timeout
//   FLG_*          - bit positions inside the 4-bit multiplier flag word
//   FLG_ERR_MASK   - flags that raise err (inexact alone does not)
//   IN_BEATS / OUT_BEATS - beat counts for the default widths
package fpmul_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    DRAIN  = 3'd5
  } state_t;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  localparam logic [3:0] FLG_ERR_MASK = (4'b1 << FLG_INVALID)
                                      | (4'b1 << FLG_OVERFLOW)
                                      | (4'b1 << FLG_UNDERFLOW);

  localparam int FP_W_DEF   = 32;
  localparam int DIN_W_DEF  = 16;
  localparam int DOUT_W_DEF = 8;

  function automatic int beat_count(input int total_w, input int beat_w);
    return total_w / beat_w;
  endfunction

  localparam int IN_BEATS  = FP_W_DEF / DIN_W_DEF;
  localparam int OUT_BEATS = FP_W_DEF / DOUT_W_DEF;

endpackage

// File: rtl/fpmul_io_sequencer_if.sv
// fpmul_io_sequencer_if: bundles the three buses around the sequencer.
//   operand input stream : in_data, in_valid, in_ready
//   result output stream : out_data, out_valid, out_ack
//   multiplier core bus  : mul_a, mul_b, mul_start, mul_done, mul_result, mul_flags
// master = sequencer view, slave = pads + multiplier view.
interface fpmul_io_sequencer_if
  import fpmul_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF,
  parameter int FP_W   = FP_W_DEF
);
  logic [DIN_W-1:0]  in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DOUT_W-1:0] out_data;
  logic              out_valid;
  logic              out_ack;
  logic [FP_W-1:0]   mul_a;
  logic [FP_W-1:0]   mul_b;
  logic              mul_start;
  logic              mul_done;
  logic [FP_W-1:0]   mul_result;
  logic [3:0]        mul_flags;

  modport master (
    input  in_data, in_valid, out_ack, mul_done, mul_result, mul_flags,
    output in_ready, out_data, out_valid, mul_a, mul_b, mul_start
  );

  modport slave (
    output in_data, in_valid, out_ack, mul_done, mul_result, mul_flags,
    input  in_ready, out_data, out_valid, mul_a, mul_b, mul_start
  );
endinterface

// File: rtl/fpmul_io_sequencer_beat_serializer.sv
// fpmul_beat_serializer: holds the product and streams it out DOUT_W bits
// at a time, least significant beat first, with a valid/ack handshake.
//   clk, rst   - clock, synchronous active-high reset
//   clear      - drop any beat in flight (abort)
//   load       - capture load_data and start presenting beat 0 next cycle
//   out_data   - current beat, held while out_ack is low
//   out_valid  - beat presented
//   out_ack    - consumer took the beat
//   last_ack   - the final beat is being acknowledged this cycle
module fpmul_beat_serializer
  import fpmul_pkg::*;
#(
  parameter int FP_W   = FP_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [FP_W-1:0]   load_data,
  output logic [DOUT_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ack,
  output logic              last_ack
);
  localparam int OUT_BEATS_L = beat_count(FP_W, DOUT_W);
  localparam int OCNT_W      = $clog2(OUT_BEATS_L + 1);
  localparam logic [OCNT_W-1:0] OUT_LAST = OCNT_W'(OUT_BEATS_L - 1);

  logic [FP_W-1:0]   result;
  logic [OCNT_W-1:0] beat_idx;
  logic              valid_q;
  logic              take;

  assign take      = valid_q & out_ack;
  assign last_ack  = take & (beat_idx == OUT_LAST);
  assign out_valid = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      beat_idx <= '0;
      valid_q  <= 1'b0;
    end else if (clear) begin
      beat_idx <= '0;
      valid_q  <= 1'b0;
    end else if (load) begin
      result   <= load_data;
      beat_idx <= '0;
      valid_q  <= 1'b1;
    end else if (take) begin
      if (beat_idx == OUT_LAST) begin
        beat_idx <= '0;
        valid_q  <= 1'b0;
      end else begin
        beat_idx <= beat_idx + OCNT_W'(1);
      end
    end
  end

  // Beat selection from the registered index keeps out_data stable under backpressure.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < OUT_BEATS_L; i++) begin
      if (beat_idx == OCNT_W'(i)) out_data = result[i*DOUT_W +: DOUT_W];
    end
  end
endmodule

// File: rtl/fpmul_io_sequencer.sv
// fpmul_io_sequencer: collects two FP_W operands from the DIN_W input bus
// (low half first), launches the multiplier, and streams the product back
// over the DOUT_W output bus (low byte first).
//   wb_clk_i, wb_rst_i - clock, synchronous active-high reset
//   bus (master)       - operand stream, result stream, multiplier bus
//   abort              - return to IDLE discarding the transaction (err kept)
//   busy               - high in every state except IDLE
//   err                - sticky: multiplier exception or timeout; cleared by
//                        reset or the first accepted beat of a new transaction
// Optional build macro FPMUL_SEQ_TIMEOUT_EN: after MUL_TIMEOUT cycles in WAIT
// without mul_done, a quiet NaN is drained and err is set.
module fpmul_io_sequencer
  import fpmul_pkg::*;
#(
  parameter int DIN_W       = DIN_W_DEF,
  parameter int DOUT_W      = DOUT_W_DEF,
  parameter int FP_W        = FP_W_DEF,
  parameter int MUL_TIMEOUT = 64
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  fpmul_io_sequencer_if.master bus,
  input  logic abort,
  output logic busy,
  output logic err
);
  localparam int IN_BEATS_L = beat_count(FP_W, DIN_W);
  localparam int ICNT_W     = $clog2(IN_BEATS_L + 1);
  localparam logic [ICNT_W-1:0] IN_LAST = ICNT_W'(IN_BEATS_L - 1);

  if ((FP_W % DIN_W) != 0 || (FP_W % DOUT_W) != 0 || MUL_TIMEOUT < 1) begin : g_bad_cfg
    $error("fpmul_io_sequencer: FP_W must be a multiple of DIN_W and DOUT_W, MUL_TIMEOUT >= 1");
  end

  state_t            state, state_nxt;
  logic [ICNT_W-1:0] in_cnt;
  logic [FP_W-1:0]   mul_a_q, mul_b_q;
  logic              err_q;

  logic              in_ready_c;
  logic              accept;
  logic              last_beat;
  logic              fill_b;
  logic              first_beat;
  logic              drain_load;
  logic [FP_W-1:0]   drain_data;
  logic              set_err;
  logic              exc_flag;
  logic              last_ack;
  logic              tmo_expire;

`ifdef FPMUL_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(MUL_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MUL_TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Counts WAIT cycles; any other state holds it at zero so it restarts on entry.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state != WAIT) tmo_cnt <= '0;
    else                           tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  assign tmo_expire = (state == WAIT) && (tmo_cnt == TMO_LAST);
`else
  assign tmo_expire = 1'b0;
`endif

  assign exc_flag   = |(bus.mul_flags & FLG_ERR_MASK);
  assign in_ready_c = (state == IDLE) || (state == LOAD_A) || (state == LOAD_B);
  assign accept     = bus.in_valid & in_ready_c & ~abort;
  assign last_beat  = (in_cnt == IN_LAST);
  assign fill_b     = (state == LOAD_B);
  assign first_beat = accept & (state == IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // IDLE behaves as the first LOAD_A slot: in_cnt is zero there.
  always_comb begin
    state_nxt  = state;
    drain_load = 1'b0;
    drain_data = bus.mul_result;
    set_err    = 1'b0;
    case (state)
      IDLE, LOAD_A: begin
        if (accept) state_nxt = last_beat ? LOAD_B : LOAD_A;
      end
      LOAD_B: begin
        if (accept && last_beat) state_nxt = START;
      end
      START: state_nxt = WAIT;
      WAIT: begin
        if (bus.mul_done) begin
          drain_load = 1'b1;
          set_err    = exc_flag;
          state_nxt  = DRAIN;
        end else if (tmo_expire) begin
          drain_load = 1'b1;
          drain_data = FP_W'(FP_QNAN);
          set_err    = 1'b1;
          state_nxt  = DRAIN;
        end
      end
      DRAIN: begin
        if (last_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt  = IDLE;
      drain_load = 1'b0;
      set_err    = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      in_cnt  <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (abort) begin
        in_cnt <= '0;
      end else if (accept) begin
        in_cnt <= last_beat ? '0 : in_cnt + ICNT_W'(1);
        for (int i = 0; i < IN_BEATS_L; i++) begin
          if (in_cnt == ICNT_W'(i)) begin
            if (fill_b) mul_b_q[i*DIN_W +: DIN_W] <= bus.in_data;
            else        mul_a_q[i*DIN_W +: DIN_W] <= bus.in_data;
          end
        end
      end
      if (set_err)         err_q <= 1'b1;
      else if (first_beat) err_q <= 1'b0;
    end
  end

  fpmul_beat_serializer #(
    .FP_W   (FP_W),
    .DOUT_W (DOUT_W)
  ) u_ser (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .clear     (abort),
    .load      (drain_load),
    .load_data (drain_data),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .out_ack   (bus.out_ack),
    .last_ack  (last_ack)
  );

  assign bus.in_ready  = in_ready_c;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  // Reset and abort both outrank the launch.
  assign bus.mul_start = (state == START) & ~abort & ~wb_rst_i;
  assign busy          = (state != IDLE);
  assign err           = err_q;
endmodule

// File: tb/tb_fpmul_io_sequencer.sv
module tb_fpmul_io_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic abort;
  logic busy;
  logic err;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_err;
  logic [31:0] cur_a, cur_b;

  fpmul_io_sequencer_if bus();

  fpmul_io_sequencer dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus),
    .abort    (abort),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed up to nb operand beats (A low, A high, B low, B high); optional random gaps.
  task automatic load_ops(input logic [31:0] a, input logic [31:0] b, input bit gaps, input int nb);
    logic [15:0] beats [4];
    int   idx;
    int   guard;
    logic rdy;
    logic took;
    beats[0] = a[15:0];
    beats[1] = a[31:16];
    beats[2] = b[15:0];
    beats[3] = b[31:16];
    cur_a = a;
    cur_b = b;
    idx   = 0;
    guard = 0;
    while (idx < nb && guard < 100) begin
      guard++;
      bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_data  = bus.in_valid ? beats[idx] : 16'($urandom);
      rdy  = bus.in_ready;
      took = bus.in_valid & rdy;
      if (bus.in_valid) chk("in_ready_load", rdy, 1);
      step();
      if (took) begin
        if (idx == 0) begin
          exp_err = 1'b0;
          chk("err_clear_first_beat", err, exp_err);
        end
        idx++;
      end
    end
    bus.in_valid = 1'b0;
    if (idx != nb) chk("load_bound", idx, nb);
    if (nb == 4) begin
      chk("mul_start_pulse", bus.mul_start, 1);
      chk("in_ready_drop", bus.in_ready, 0);
      chk("busy_start", busy, 1);
      chk("mul_a", bus.mul_a, a);
      chk("mul_b", bus.mul_b, b);
    end
  endtask

  // From START: one stray beat (must be ignored), then mul_done after lat WAIT cycles.
  task automatic do_mul(input logic [31:0] res, input logic [3:0] flags, input int lat);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hDEAD;
    step();
    bus.in_valid = 1'b0;
    chk("mul_start_one_cycle", bus.mul_start, 0);
    repeat (lat) begin
      step();
      chk("no_early_out", bus.out_valid, 0);
      chk("no_second_start", bus.mul_start, 0);
    end
    bus.mul_done   = 1'b1;
    bus.mul_result = res;
    bus.mul_flags  = flags;
    step();
    bus.mul_done   = 1'b0;
    bus.mul_result = $urandom;
    bus.mul_flags  = 4'($urandom);
    if (flags[3] | flags[2] | flags[1]) exp_err = 1'b1;
    chk("out_valid_after_done", bus.out_valid, 1);
    chk("err_after_done", err, exp_err);
    chk("mul_a_stable", bus.mul_a, cur_a);
    chk("mul_b_stable", bus.mul_b, cur_b);
  endtask

  // ack_mode: 0 always ack, 1 random ack, 2 hold ack low 3 cycles on beat 1.
  task automatic drain(input logic [31:0] res, input int ack_mode, input int stop_after);
    int   k;
    int   hold;
    int   guard;
    logic ack;
    k = 0; hold = 0; guard = 0;
    while (k < 4 && guard < 200) begin
      guard++;
      chk("drain_valid", bus.out_valid, 1);
      chk("drain_byte", bus.out_data, (res >> (8 * k)) & 32'hFF);
      case (ack_mode)
        0:       ack = 1'b1;
        1:       ack = 1'($urandom_range(0, 1));
        default: begin
          ack = !(k == 1 && hold < 3);
          if (!ack) hold++;
        end
      endcase
      bus.out_ack = ack;
      step();
      bus.out_ack = 1'b0;
      if (ack) k++;
      if (k == stop_after) return;
    end
    if (k != 4) chk("drain_bound", k, 4);
    chk("drain_end_valid", bus.out_valid, 0);
    chk("drain_end_busy", busy, 0);
    chk("drain_end_ready", bus.in_ready, 1);
    if (ack_mode == 2) chk("backpressure_hold_cycles", hold, 3);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_mul_start"}, bus.mul_start, 0);
    chk({tag, "_err"}, err, exp_err);
  endtask

  initial begin
    logic [31:0] ra, rb, rr;
    logic [3:0]  rf;
    rst = 1'b1; abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ack = 1'b0;
    bus.mul_done = 1'b0; bus.mul_result = '0; bus.mul_flags = '0;
    exp_err = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_mul_start", bus.mul_start, 0);
    chk("rst_mul_a", bus.mul_a, 0);
    chk("rst_mul_b", bus.mul_b, 0);
    rst = 1'b0;
    step();

    // 1.5 * 2.0 = 3.0
    load_ops(32'h3FC0_0000, 32'h4000_0000, 1'b0, 4);
    do_mul(32'h4040_0000, 4'b0000, 5);
    drain(32'h4040_0000, 0, -1);
    chk("t1_err", err, 0);

    // output backpressure on the second beat
    load_ops(32'h3FC0_0000, 32'h4000_0000, 1'b0, 4);
    do_mul(32'h4040_0000, 4'b0000, 2);
    drain(32'h4040_0000, 2, -1);

    // overflow flag sets err; err stays through IDLE
    load_ops(32'h7F00_0000, 32'h7F00_0000, 1'b0, 4);
    do_mul(32'h7F80_0000, 4'b0100, 2);
    drain(32'h7F80_0000, 0, -1);
    chk("err_sticky_idle", err, 1);

    // next transaction clears err on first beat; inexact alone does not set it
    load_ops(32'h3F80_0001, 32'h3F80_0001, 1'b1, 4);
    do_mul(32'h3F80_0002, 4'b0001, 0);
    drain(32'h3F80_0002, 0, -1);
    chk("inexact_no_err", err, 0);

    // mul_done outside WAIT is ignored
    bus.mul_done = 1'b1; bus.mul_result = 32'h1234_5678;
    step();
    bus.mul_done = 1'b0;
    check_idle("stray_done");

    // abort after 3 beats, then a fresh load works
    load_ops(32'hAAAA_5555, 32'h1111_2222, 1'b0, 3);
    abort = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'hBEEF;
    step();
    abort = 1'b0; bus.in_valid = 1'b0;
    check_idle("abort_load");
    load_ops(32'h4120_0000, 32'h4080_0000, 1'b0, 4);
    do_mul(32'h4220_0000, 4'b0000, 3);
    drain(32'h4220_0000, 1, -1);

    // abort coinciding with START suppresses mul_start
    load_ops(32'h4000_0000, 32'h4000_0000, 1'b0, 4);
    abort = 1'b1;
    #1;
    chk("abort_start_suppress", bus.mul_start, 0);
    step();
    abort = 1'b0;
    check_idle("abort_start");
    repeat (3) begin
      step();
      chk("abort_start_quiet", bus.mul_start, 0);
    end

    // abort in DRAIN keeps err
    load_ops(32'h0080_0000, 32'h0000_0001, 1'b0, 4);
    do_mul(32'h0000_0000, 4'b0010, 1);
    drain(32'h0000_0000, 0, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("abort_drain");
    chk("abort_keeps_err", err, 1);

    // multiplier never answers
    load_ops(32'h3F80_0000, 32'h3F80_0000, 1'b0, 4);
`ifdef FPMUL_SEQ_TIMEOUT_EN
    repeat (64) begin
      step();
      chk("tmo_wait", bus.out_valid, 0);
    end
    step();
    exp_err = 1'b1;
    chk("tmo_valid", bus.out_valid, 1);
    chk("tmo_err", err, 1);
    drain(32'h7FC0_0000, 0, -1);
`else
    repeat (200) step();
    chk("wait_busy", busy, 1);
    chk("wait_no_out", bus.out_valid, 0);
    chk("wait_in_ready", bus.in_ready, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("wait_abort");
`endif

    // reset mid-DRAIN after the first byte
    load_ops(32'h7F00_0000, 32'h4000_0000, 1'b0, 4);
    do_mul(32'h7F80_0000, 4'b0100, 3);
    drain(32'h7F80_0000, 0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_err = 1'b0;
    check_idle("rst_drain");
    chk("rst_drain_out_data", bus.out_data, 0);
    chk("rst_drain_mul_a", bus.mul_a, 0);
    chk("rst_drain_mul_b", bus.mul_b, 0);
    step();
    chk("rst_drain_no_resume", bus.out_valid, 0);

    // randomized transactions
    for (int t = 0; t < 25; t++) begin
      ra = $urandom; rb = $urandom; rr = $urandom; rf = 4'($urandom);
      load_ops(ra, rb, 1'b1, 4);
      do_mul(rr, rf, int'($urandom_range(0, 6)));
      drain(rr, 1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fpmul_io_sequencer.md
Name: fpmul_io_sequencer

Overview:
- Sequences the single-precision floating-point multiplier core behind the narrow chip I/O pins.
- Collects two 32-bit IEEE-754 operands from a 16-bit input bus (low half first), launches the multiplier with a start/done handshake, then streams the 32-bit product back over an 8-bit output bus.
- Sits between the pad-facing io_in/io_out slices and the multiplier datapath inside the user project macro.

Parameters:
- DIN_W, 16, input data bus width; FP_W must be a multiple of DIN_W.
- DOUT_W, 8, output data bus width; FP_W must be a multiple of DOUT_W.
- FP_W, 32, operand/result width.
- MUL_TIMEOUT, 64, cycles allowed for mul_done (used only with the optional feature).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset.
- in_data  in  DIN_W  operand beat.
- in_valid  in  1  beat strobe; one beat per cycle when high and in_ready=1.
- in_ready  out  1  sequencer accepting operand beats.
- abort  in  1  return to IDLE, discarding state.
- out_data  out  DOUT_W  result beat.
- out_valid  out  1  out_data valid.
- out_ack  in  1  consumer took the beat.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky exception/timeout indicator.
- mul_a  out  FP_W  operand A to the multiplier.
- mul_b  out  FP_W  operand B to the multiplier.
- mul_start  out  1  one-cycle launch pulse.
- mul_done  in  1  one-cycle completion pulse.
- mul_result  in  FP_W  product, valid with mul_done.
- mul_flags  in  4  {invalid, overflow, underflow, inexact}, valid with mul_done.

Behaviour:
- Clocking and reset: single clock wb_clk_i; wb_rst_i is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, err=0, mul_start=0, mul_a=0, mul_b=0, beat counters=0.
- State IDLE:
  - First accepted beat is written to mul_a[DIN_W-1:0]; go to LOAD_A.
- State LOAD_A:
  - Beats fill mul_a from the low half upward.
  - After FP_W/DIN_W beats (2 by default), go to LOAD_B.
  - Gaps with in_valid=0 are allowed and hold state.
- State LOAD_B:
  - Same fill scheme into mul_b.
  - Last beat moves to START; in_ready drops in the cycle after the last beat.
- State START:
  - mul_start=1 for exactly one cycle; go to WAIT.
  - mul_a and mul_b stay stable until the next IDLE→LOAD_A transition.
- State WAIT:
  - On mul_done: capture mul_result into the result register; set err if mul_flags[3:1] is nonzero (inexact alone does not set err); go to DRAIN.
- State DRAIN:
  - out_valid=1 with out_data = result[DOUT_W*k +: DOUT_W], k=0..3, low byte first.
  - k advances on out_valid & out_ack.
  - out_data is held stable while out_ack=0.
  - Acknowledge of the last beat drops out_valid and returns to IDLE with in_ready=1 in the next cycle.
- Timing:
  - Latency from the last operand beat to mul_start is 1 cycle.
  - Latency from mul_done to first out_valid is 1 cycle.
- in_valid while in_ready=0 is ignored, with no side effects.
- mul_done outside WAIT is ignored.
- abort:
  - In any state, next cycle is IDLE with counters cleared, out_valid=0, in_ready=1.
  - err is kept; mul_start is suppressed if abort coincides with START.
- Priority when events coincide: wb_rst_i > abort > handshake.
- err clears only on reset or on the first accepted beat of a new transaction.
- Reset mid-transaction returns everything to reset values in the next cycle; no partial result is emitted.

Optional Feature:
- Macro: FPMUL_SEQ_TIMEOUT_EN.
- With the macro: a counter runs in WAIT, cleared on entry. If MUL_TIMEOUT cycles elapse without mul_done:
  - load result = 32'h7FC00000 (qNaN);
  - set err;
  - go to DRAIN.
  - mul_done arriving in the same cycle as expiry wins.
- Without the macro: WAIT holds indefinitely until mul_done or abort; no counter logic is synthesized.

Decomposition:
- Package fpmul_pkg holds:
  - state enum {IDLE, LOAD_A, LOAD_B, START, WAIT, DRAIN};
  - FP_QNAN = 32'h7FC00000;
  - flag bit index constants FLG_INVALID=3, FLG_OVERFLOW=2, FLG_UNDERFLOW=1, FLG_INEXACT=0;
  - the derived beat counts (FP_W/DIN_W, FP_W/DOUT_W).
- One natural sub-module: fpmul_beat_serializer, the DRAIN-side width converter (result register, beat counter, valid/ack handshake).
- The FSM and operand assembly stay in the top block.

Test Plan:
- Operand load and drain:
  - Stimulus: beats 0x0000, 0x3FC0 (A=1.5), then 0x0000, 0x4000 (B=2.0); model returns 0x40400000 after 5 cycles.
  - Response: mul_a=0x3FC00000, mul_b=0x40000000, one mul_start pulse; out_data sequence 0x00,0x00,0x40,0x40; err=0.
- Output backpressure: hold out_ack low 3 cycles on the second beat → out_data stays 0x00 and out_valid stays high; beat order unchanged; no beat lost.
- Flag handling:
  - Model returns flags=4'b0100 (overflow) with 0x7F800000 → err=1 and bytes 0x00,0x00,0x80,0x7F.
  - err clears on the next transaction's first beat.
- Abort mid-load: assert abort after 3 operand beats → next cycle IDLE, in_ready=1, no mul_start; a fresh 4-beat load then works normally.
- Timeout (FPMUL_SEQ_TIMEOUT_EN, MUL_TIMEOUT=64):
  - Stimulus: model never raises mul_done.
  - Response: 64 cycles after mul_start, DRAIN emits 0x00,0x00,0xC0,0x7F with err=1.
  - Without the macro: still in WAIT at cycle 200.
- Reset mid-DRAIN: assert wb_rst_i after the first result byte → next cycle out_valid=0, busy=0, err=0, in_ready=1.
